// File: rtl/cms_pix28_package.sv
// Shared command-word layout, op codes, status bit map and decoder state
// encoding for the firmware command path.
package cms_pix28_package;

  localparam int windex_device_id_hi = 31;
  localparam int windex_device_id_lo = 28;
  localparam int windex_op_code_hi   = 27;
  localparam int windex_op_code_lo   = 24;
  localparam int windex_body_hi      = 23;
  localparam int windex_body_lo      = 0;

  localparam logic [3:0] firmware_id_1 = 4'b0001;
  localparam logic [3:0] firmware_id_2 = 4'b0010;
  localparam logic [3:0] firmware_id_3 = 4'b0100;
  localparam logic [3:0] firmware_id_4 = 4'b1000;

  localparam logic [3:0] test_number_1 = 4'b0001;
  localparam logic [3:0] test_number_2 = 4'b0010;
  localparam logic [3:0] test_number_3 = 4'b0100;
  localparam logic [3:0] test_number_4 = 4'b1000;

  typedef enum logic [3:0] {
    OP_CODE_NOOP              = 4'h0,
    OP_CODE_W_RST_FW          = 4'h1,
    OP_CODE_W_CFG_STATIC_0    = 4'h2,
    OP_CODE_R_CFG_STATIC_0    = 4'h3,
    OP_CODE_W_CFG_STATIC_1    = 4'h4,
    OP_CODE_R_CFG_STATIC_1    = 4'h5,
    OP_CODE_W_CFG_ARRAY_0     = 4'h6,
    OP_CODE_R_CFG_ARRAY_0     = 4'h7,
    OP_CODE_W_CFG_ARRAY_1     = 4'h8,
    OP_CODE_R_CFG_ARRAY_1     = 4'h9,
    OP_CODE_W_CFG_ARRAY_2     = 4'hA,
    OP_CODE_R_CFG_ARRAY_2     = 4'hB,
    OP_CODE_R_DATA_ARRAY_0    = 4'hC,
    OP_CODE_R_DATA_ARRAY_1    = 4'hD,
    OP_CODE_W_STATUS_FW_CLEAR = 4'hE,
    OP_CODE_W_EXECUTE         = 4'hF
  } op_code_t;

  localparam int status_index_rst_fw         = 0;
  localparam int status_index_w_cfg_static_0 = 1;
  localparam int status_index_r_cfg_static_0 = 2;
  localparam int status_index_w_cfg_static_1 = 3;
  localparam int status_index_r_cfg_static_1 = 4;
  localparam int status_index_w_cfg_array_0  = 5;
  localparam int status_index_r_cfg_array_0  = 6;
  localparam int status_index_w_cfg_array_1  = 7;
  localparam int status_index_r_cfg_array_1  = 8;
  localparam int status_index_w_cfg_array_2  = 9;
  localparam int status_index_r_cfg_array_2  = 10;
  localparam int status_index_r_data_array_0 = 11;
  localparam int status_index_r_data_array_1 = 12;
  localparam int status_index_execute        = 13;
  localparam int status_index_test_done_1    = 14;
  localparam int status_index_error          = 31;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DECODE    = 2'b01,
    EXEC_BUSY = 2'b10
  } state_t_fw_cmd_decoder;

  // Status bit raised by a configuration read/write op code.
  function automatic logic [4:0] op_status_index(input op_code_t op);
    case (op)
      OP_CODE_W_CFG_STATIC_0: return 5'(status_index_w_cfg_static_0);
      OP_CODE_R_CFG_STATIC_0: return 5'(status_index_r_cfg_static_0);
      OP_CODE_W_CFG_STATIC_1: return 5'(status_index_w_cfg_static_1);
      OP_CODE_R_CFG_STATIC_1: return 5'(status_index_r_cfg_static_1);
      OP_CODE_W_CFG_ARRAY_0:  return 5'(status_index_w_cfg_array_0);
      OP_CODE_R_CFG_ARRAY_0:  return 5'(status_index_r_cfg_array_0);
      OP_CODE_W_CFG_ARRAY_1:  return 5'(status_index_w_cfg_array_1);
      OP_CODE_R_CFG_ARRAY_1:  return 5'(status_index_r_cfg_array_1);
      OP_CODE_W_CFG_ARRAY_2:  return 5'(status_index_w_cfg_array_2);
      OP_CODE_R_CFG_ARRAY_2:  return 5'(status_index_r_cfg_array_2);
      OP_CODE_R_DATA_ARRAY_0: return 5'(status_index_r_data_array_0);
      OP_CODE_R_DATA_ARRAY_1: return 5'(status_index_r_data_array_1);
      default:                return 5'(status_index_error);
    endcase
  endfunction

  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/fw_exec_watchdog.sv
// Execution watchdog: 27-bit up-counter with clear/enable and a terminal-count
// flag that holds once the limit is reached.
module fw_exec_watchdog #(
  parameter int LIMIT = 2**27
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [26:0] r_count;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + 27'd1;
    end
  end

  assign o_terminal = (r_count == 27'(LIMIT - 1));

endmodule

// File: rtl/fw_cmd_decoder.sv
// Firmware command front-end: filters command words by device id, decodes the
// op code, updates config/status registers and supervises test execution.
module fw_cmd_decoder
  import cms_pix28_package::*;
#(
  parameter logic [3:0] FIRMWARE_ID     = firmware_id_1,
  parameter int         TEST_NUMBER_LSB = 14,
  parameter int         EXEC_TIMEOUT    = 2**27
) (
  input  logic        i_fw_axi_clk,
  input  logic        i_fw_rst,
  input  logic [31:0] i_cmd_word,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  output logic        o_fw_rst_req,
  output logic [23:0] o_cfg_static_0_reg,
  output logic [23:0] o_cfg_static_1_reg,
  output logic [2:0]  o_cfg_array_wr_en,
  output logic [23:0] o_cfg_array_wr_data,
  output logic        o_rd_req,
  output logic [3:0]  o_rd_sel,
  output logic [23:0] o_execute_cfg,
  output logic        o_execute_start,
  input  logic [3:0]  i_test_done,
  output logic [31:0] o_status
);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_DECODE    = DECODE;
  localparam logic [1:0] ST_EXEC_BUSY = EXEC_BUSY;

  logic [1:0]  r_state;
  logic [31:0] r_cmd;
  logic        r_fw_rst_req;
  logic [23:0] r_cfg_static_0;
  logic [23:0] r_cfg_static_1;
  logic [2:0]  r_cfg_array_wr_en;
  logic [23:0] r_cfg_array_wr_data;
  logic        r_rd_req;
  logic [3:0]  r_rd_sel;
  logic [23:0] r_execute_cfg;
  logic        r_execute_start;
  logic [31:0] r_status;

  logic [3:0]  w_device_id;
  op_code_t    w_op_code;
  logic [23:0] w_body;
  logic [3:0]  w_cmd_tn;
  logic [3:0]  w_busy_tn;
  logic        w_accept;
  logic        w_done_hit;
  logic        w_timeout;

  assign w_device_id = r_cmd[windex_device_id_hi:windex_device_id_lo];
  assign w_op_code   = op_code_t'(r_cmd[windex_op_code_hi:windex_op_code_lo]);
  assign w_body      = r_cmd[windex_body_hi:windex_body_lo];
  assign w_cmd_tn    = w_body[TEST_NUMBER_LSB +: 4];
  assign w_busy_tn   = r_execute_cfg[TEST_NUMBER_LSB +: 4];
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_done_hit  = |(i_test_done & w_busy_tn);

  fw_exec_watchdog #(
    .LIMIT (EXEC_TIMEOUT)
  ) u_watchdog (
    .i_clk      (i_fw_axi_clk),
    .i_rst      (i_fw_rst),
    .i_clear    (r_state == ST_DECODE),
    .i_enable   (r_state == ST_EXEC_BUSY),
    .o_terminal (w_timeout)
  );

  always_ff @(posedge i_fw_axi_clk) begin
    if (i_fw_rst) begin
      r_state             <= ST_IDLE;
      r_cmd               <= '0;
      r_fw_rst_req        <= 1'b0;
      r_cfg_static_0      <= '0;
      r_cfg_static_1      <= '0;
      r_cfg_array_wr_en   <= '0;
      r_cfg_array_wr_data <= '0;
      r_rd_req            <= 1'b0;
      r_rd_sel            <= '0;
      r_execute_cfg       <= '0;
      r_execute_start     <= 1'b0;
      r_status            <= '0;
    end else begin
      // Strobes default low so each command produces exactly one-cycle pulses.
      r_fw_rst_req        <= 1'b0;
      r_cfg_array_wr_en   <= '0;
      r_cfg_array_wr_data <= '0;
      r_rd_req            <= 1'b0;
      r_execute_start     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmd   <= i_cmd_word;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          r_state <= ST_IDLE;
          if (w_device_id == FIRMWARE_ID) begin
            case (w_op_code)
              OP_CODE_W_RST_FW: begin
                r_fw_rst_req   <= 1'b1;
                r_cfg_static_0 <= '0;
                r_cfg_static_1 <= '0;
                r_status       <= 32'd1 << status_index_rst_fw;
              end
              OP_CODE_W_CFG_STATIC_0: begin
                r_cfg_static_0                      <= w_body;
                r_status[op_status_index(w_op_code)] <= 1'b1;
              end
              OP_CODE_W_CFG_STATIC_1: begin
                r_cfg_static_1                      <= w_body;
                r_status[op_status_index(w_op_code)] <= 1'b1;
              end
              OP_CODE_W_CFG_ARRAY_0, OP_CODE_W_CFG_ARRAY_1, OP_CODE_W_CFG_ARRAY_2: begin
                r_cfg_array_wr_en[w_op_code[2:1] - 2'd3] <= 1'b1;
                r_cfg_array_wr_data                      <= w_body;
                r_status[op_status_index(w_op_code)]     <= 1'b1;
              end
              OP_CODE_R_CFG_STATIC_0, OP_CODE_R_CFG_STATIC_1, OP_CODE_R_CFG_ARRAY_0,
              OP_CODE_R_CFG_ARRAY_1, OP_CODE_R_CFG_ARRAY_2, OP_CODE_R_DATA_ARRAY_0,
              OP_CODE_R_DATA_ARRAY_1: begin
                r_rd_req                             <= 1'b1;
                r_rd_sel                             <= w_op_code;
                r_status[op_status_index(w_op_code)] <= 1'b1;
              end
              OP_CODE_W_STATUS_FW_CLEAR: r_status <= '0;
              OP_CODE_W_EXECUTE: begin
                if (is_one_hot4(w_cmd_tn)) begin
                  r_execute_cfg                  <= w_body;
                  r_execute_start                <= 1'b1;
                  r_status[status_index_execute] <= 1'b1;
                  r_state                        <= ST_EXEC_BUSY;
                end else begin
                  r_status[status_index_error] <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        ST_EXEC_BUSY: begin
          // A matching done beats a watchdog expiry in the same cycle.
          if (w_done_hit) begin
            r_status[status_index_test_done_1 +: 4] <=
              r_status[status_index_test_done_1 +: 4] | w_busy_tn;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_status[status_index_error] <= 1'b1;
            r_state                      <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready         = (r_state == ST_IDLE) && !i_fw_rst;
  assign o_fw_rst_req        = r_fw_rst_req;
  assign o_cfg_static_0_reg  = r_cfg_static_0;
  assign o_cfg_static_1_reg  = r_cfg_static_1;
  assign o_cfg_array_wr_en   = r_cfg_array_wr_en;
  assign o_cfg_array_wr_data = r_cfg_array_wr_data;
  assign o_rd_req            = r_rd_req;
  assign o_rd_sel            = r_rd_sel;
  assign o_execute_cfg       = r_execute_cfg;
  assign o_execute_start     = r_execute_start;
  assign o_status            = r_status;

endmodule
